// File: rtl/log2_fixed_seq.sv
// Sequential fixed-point log2 with optional per-octave scaling.
// Integer part from leading-one, fraction bits by iterative squaring.
module log2_fixed_seq #(
  parameter int IN_WIDTH    = 32,
  parameter int FRAC_BITS   = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE       = 6,
  parameter int SCALE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  number_i,
  input  logic                 mode_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [OUT_WIDTH-1:0] log_o,
  output logic                 zero_o,
  output logic                 sat_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int W  = IN_WIDTH;
  localparam int EW = (W > 1) ? $clog2(W) : 1;
  localparam int FW = (FRAC_BITS > 0) ? FRAC_BITS : 1;
  localparam int LW = EW + FRAC_BITS;
  localparam int PW = LW + SCALE_WIDTH;
  localparam int CW = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 1;
  localparam int NW = $clog2(FW + 1);
  localparam logic [NW-1:0] LAST =
    NW'((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_FRAC,
    S_SCALE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]         r_num;
  logic                 r_mode;
  logic [W-1:0]         r_mant;
  logic [EW-1:0]        r_exp;
  logic [FW-1:0]        r_frac;
  logic [NW-1:0]        r_cnt;
  logic                 r_zero;
  logic                 r_ready;
  logic [OUT_WIDTH-1:0] r_log;
  logic                 r_zero_o;
  logic                 r_sat;

  logic [EW-1:0]  w_exp;
  logic [W-1:0]   w_mant;
  logic [2*W-1:0] w_sq;
  logic [W-1:0]   w_mnext;
  logic           w_bit;
  logic [LW-1:0]  w_l;
  logic [PW-1:0]  w_prod;
  logic [CW-1:0]  w_res;
  logic [CW-1:0]  w_max;
  logic           w_sat;
  logic           w_unused;

  always_comb begin
    w_exp = '0;
    for (int i = 0; i < W; i++) begin
      if (r_num[i]) w_exp = EW'(i);
    end
  end

  assign w_mant  = r_num << (EW'(W - 1) - w_exp);
  assign w_sq    = {{W{1'b0}}, r_mant} * {{W{1'b0}}, r_mant};
  assign w_bit   = w_sq[2*W-1] & ~r_zero;
  assign w_mnext = w_sq[2*W-1] ? w_sq[2*W-1:W] : w_sq[2*W-2:W-1];
  assign w_unused = ^w_sq[W-2:0];

  // L = E*2^FRAC_BITS + F, then optional octave scaling with floor
  assign w_l    = (LW'(r_exp) << FRAC_BITS) | LW'(r_frac);
  assign w_prod = PW'(w_l) * PW'(SCALE);
  assign w_res  = r_mode ? CW'(w_l) : CW'(w_prod >> FRAC_BITS);
  assign w_max  = (CW'(1) << OUT_WIDTH) - CW'(1);
  assign w_sat  = (w_res > w_max);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (valid_i && r_ready) w_next = S_NORM;
      S_NORM:  w_next = (FRAC_BITS > 0) ? S_FRAC : S_SCALE;
      S_FRAC:  if (r_cnt == LAST) w_next = S_SCALE;
      S_SCALE: w_next = S_DONE;
      S_DONE:  if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_num    <= '0;
      r_mode   <= 1'b0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_frac   <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_log    <= '0;
      r_zero_o <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (valid_i && r_ready) begin
            r_num  <= number_i;
            r_mode <= mode_i;
          end
        end
        S_NORM: begin
          r_exp  <= w_exp;
          r_mant <= w_mant;
          r_zero <= (r_num == '0);
          r_frac <= '0;
          r_cnt  <= '0;
        end
        S_FRAC: begin
          r_mant <= w_mnext;
          r_frac <= (r_frac << 1) | FW'(w_bit);
          r_cnt  <= r_cnt + NW'(1);
        end
        S_SCALE: begin
          r_log    <= w_sat ? '1 : w_res[OUT_WIDTH-1:0];
          r_zero_o <= r_zero;
          r_sat    <= w_sat;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = (r_state == S_DONE);
  assign log_o   = r_log;
  assign zero_o  = r_zero_o;
  assign sat_o   = r_sat;

endmodule

// File: tb/tb_log2_fixed_seq.sv
// Directed bench for log2_fixed_seq with default parameters.
// Inputs change at negedge; outputs sampled #1 after posedge.
module tb_log2_fixed_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] number_i;
  logic        mode_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  log_o;
  logic        zero_o;
  logic        sat_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  log2_fixed_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .number_i (number_i),
    .mode_i   (mode_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .log_o    (log_o),
    .zero_o   (zero_o),
    .sat_o    (sat_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; counts edges to valid_o.
  task automatic wait_result(input string tag, input int exp_log,
                             input logic exp_zero, input logic exp_sat);
    int lat;
    lat = 0;
    valid_i = 1'b0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid_o) break;
    end
    chk({tag, " latency"}, lat, 6);
    chk({tag, " log"}, log_o, exp_log);
    chk({tag, " zero"}, zero_o, exp_zero);
    chk({tag, " sat"}, sat_o, exp_sat);
  endtask

  task automatic run_op(input string tag, input logic [31:0] n,
                        input logic m, input int exp_log,
                        input logic exp_zero, input logic exp_sat);
    int k;
    @(negedge clk);
    number_i = n;
    mode_i   = m;
    valid_i  = 1'b1;
    k = 0;
    while (!ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    wait_result(tag, exp_log, exp_zero, exp_sat);
    // ready_i is high: the handshake happens on the next edge
    @(posedge clk);
    #1;
    chk({tag, " valid_fall"}, valid_o, 1'b0);
    chk({tag, " ready_rise"}, ready_o, 1'b1);
  endtask

  initial begin
    logic [7:0] held;
    string      nm;
    rst_n    = 1'b0;
    number_i = 32'd4;
    mode_i   = 1'b0;
    valid_i  = 1'b1;
    ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", ready_o, 1'b0);
    chk("rst valid", valid_o, 1'b0);
    chk("rst log", log_o, 0);
    chk("rst zero", zero_o, 1'b0);
    chk("rst sat", sat_o, 1'b0);

    // valid_i held across release: the release edge must not accept
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release no accept", ready_o, 1'b1);
    @(posedge clk);
    #1;
    chk("first accept", ready_o, 1'b0);
    wait_result("first op 4", 12, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("first op handshake", valid_o, 1'b0);

    for (int i = 0; i < 32; i++) begin
      nm = $sformatf("pow2 %0d", i);
      run_op(nm, 32'd1 << i, 1'b0, 6 * i, 1'b0, 1'b0);
    end

    run_op("raw 32", 32'd32, 1'b1, 80, 1'b0, 1'b0);
    run_op("raw 3", 32'd3, 1'b1, 25, 1'b0, 1'b0);
    run_op("scaled 3", 32'd3, 1'b0, 9, 1'b0, 1'b0);
    run_op("zero m0", 32'd0, 1'b0, 0, 1'b1, 1'b0);
    run_op("zero m1", 32'd0, 1'b1, 0, 1'b1, 1'b0);
    run_op("raw 2^31 sat", 32'h8000_0000, 1'b1, 255, 1'b0, 1'b1);
    run_op("scaled max", 32'hFFFF_FFFF, 1'b0, 191, 1'b0, 1'b0);
    run_op("raw 5", 32'd5, 1'b1, 37, 1'b0, 1'b0);

    // Backpressure in DONE
    @(negedge clk);
    ready_i  = 1'b0;
    number_i = 32'd1000;
    mode_i   = 1'b1;
    valid_i  = 1'b1;
    @(posedge clk);
    #1;
    wait_result("bp 1000", 159, 1'b0, 1'b0);
    held = log_o;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid_i  = ~valid_i;
      number_i = 32'd7 * c + 32'd1;
      mode_i   = c[0];
      @(posedge clk);
      #1;
      checks++;
      assert (valid_o === 1'b1 && ready_o === 1'b0 && log_o === held)
      else begin
        errors++;
        $error("FAIL bp hold: observed v%0b r%0b log%0d expected v1 r0 log%0d",
               valid_o, ready_o, log_o, held);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release valid", valid_o, 1'b0);
    chk("bp release ready", ready_o, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("bp no capture", valid_o, 1'b0);
    chk("bp idle", ready_o, 1'b1);

    // Reset during the FRAC phase
    @(negedge clk);
    number_i = 32'd12345;
    mode_i   = 1'b0;
    valid_i  = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst valid", valid_o, 1'b0);
    chk("midrst log", log_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst ready", ready_o, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst no stale", valid_o, 1'b0);
    run_op("after rst 8", 32'd8, 1'b0, 18, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/log2_fixed_seq.md
# log2_fixed_seq

Sequential, parametrised base-2 logarithm unit for the MFCC log-energy stage. It accepts an unsigned integer over a valid/ready handshake and computes floor(log2(x)) plus FRAC_BITS fractional bits by iterative squaring. It then returns either the raw fixed-point log or a version scaled by a per-octave constant (SCALE=6 gives the dB-like code used downstream), saturated to OUT_WIDTH. Each input power of two 2^i produces exactly i*SCALE in scaled mode.

## Interface
- IN_WIDTH, 32: input operand width (≥2).
- FRAC_BITS, 4: fractional log bits computed (0 allowed).
- OUT_WIDTH, 8: output width.
- SCALE, 6: per-octave multiplier, unsigned, SCALE_WIDTH bits.
- SCALE_WIDTH, 8: width of SCALE.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- number_i  in  IN_WIDTH  unsigned operand.
- mode_i  in  1  0 = scaled output, 1 = raw fixed-point log2; sampled with number_i.
- valid_i  in  1  operand valid.
- ready_o  out  1  unit can accept; high only in IDLE.
- log_o  out  OUT_WIDTH  result.
- zero_o  out  1  operand was 0.
- sat_o  out  1  result clipped to 2^OUT_WIDTH-1.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.

## Operation
- Let LW = clog2(IN_WIDTH) + FRAC_BITS. L is the fixed-point log2 with integer part E and fraction F: L = E*2^FRAC_BITS + F.
- States: IDLE, NORM, FRAC, SCALE, DONE.
- IDLE: ready_o=1. On valid_i&&ready_o, register number_i and mode_i, then go to NORM.
- NORM, one cycle:
  - E = index of leading one.
  - Mantissa m (IN_WIDTH bits, Q1.(IN_WIDTH-1)) = operand << (IN_WIDTH-1-E).
  - Clear the fraction and the bit counter.
  - Next state is FRAC, or SCALE if FRAC_BITS=0.
  - Operand 0: E=0, m=0, zero flag set.
- FRAC, FRAC_BITS cycles, MSB first:
  - sq = m*m, 2*IN_WIDTH bits.
  - If sq[2W-1]=1: bit=1, m = sq[2W-1:W].
  - Otherwise: bit=0, m = sq[2W-2:W-1].
  - Shift the bit into F. With the zero flag set, every bit is 0.
- SCALE, one cycle:
  - mode 0: R = (L*SCALE) >> FRAC_BITS, floor, full-precision product of LW+SCALE_WIDTH bits.
  - mode 1: R = L.
  - log_o = min(R, 2^OUT_WIDTH-1); sat_o = (R > 2^OUT_WIDTH-1); zero_o = zero flag.
  - Go to DONE.
- DONE: valid_o=1. log_o, zero_o and sat_o are held stable. On ready_i, go to IDLE.
- No overlap: at most one operand is in flight. valid_i outside IDLE is ignored, and the operand is not captured.
- Reset values: ready_o=0 during reset and 1 from the first cycle after release; valid_o=0, log_o=0, zero_o=0, sat_o=0; state IDLE; internal registers cleared.

## Timing
- Accept edge = edge where valid_i&&ready_o.
- valid_o rises exactly FRAC_BITS+2 edges after the accept edge (6 for defaults).
- Latency is independent of the operand value, including 0.
- Handshake edge = edge where valid_o&&ready_i.
  - valid_o falls one cycle after it.
  - ready_o rises one cycle after it, in IDLE.
- Minimum issue interval is FRAC_BITS+4 cycles when ready_i is held high.
- With ready_i low, DONE persists indefinitely. Outputs must not change.
- Reset low at any edge, any state: the next cycle is IDLE with all outputs at reset values. A partial result is never emitted.
- valid_i asserted at the reset-release edge is not accepted; the first acceptance is one edge later.

## Test plan
- Defaults, mode 0, number_i = 2^i for i=0..31 -> log_o = 6*i (0,6,…,186), zero_o=0, sat_o=0, valid_o exactly 6 edges after accept.
- Mode 1, number_i=32 -> log_o=80. number_i=3 -> log_o=25 (fraction 1001b). Mode 0, number_i=3 -> log_o=9.
- number_i=0 in either mode -> log_o=0, zero_o=1, same 6-cycle latency.
- Mode 1, number_i=2^31 -> R=496, log_o=255, sat_o=1. Mode 0, number_i=0xFFFFFFFF -> log_o=191 (L=511), sat_o=0.
- Backpressure:
  - Stimulus: hold ready_i=0 for 10 cycles in DONE while toggling valid_i and number_i.
  - Required: log_o stable, ready_o=0, no new capture.
  - On release: one handshake, then ready_o=1 on the next cycle.
- Reset mid-FRAC:
  - Stimulus: drive rst_n=0 for one edge after the third FRAC cycle.
  - Required: the next cycle is IDLE with valid_o=0 and ready_o=1, and there is no stale result.
  - A following operand 8 (mode 0) -> log_o=18.
